// File: rtl/mt9v032_pkg.sv
// Shared types and default geometry for the MT9V032 capture path.
package mt9v032_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        WAIT_SOF,
        CAP,
        DONE
    } cap_state_e;

    localparam int DEF_WIDTH  = 752;
    localparam int DEF_HEIGHT = 480;

endpackage

// File: rtl/mt9v032_capture_ctrl_if.sv
// Framed pixel stream from the capture sequencer into the downstream FIFO.
interface mt9v032_capture_ctrl_if #(
    parameter int PX_BITS = 10
);
    logic               out_valid;
    logic               out_ready;
    logic [PX_BITS-1:0] out_data;
    logic               out_sof;
    logic               out_eol;

    modport master (output out_valid, out_data, out_sof, out_eol, input out_ready);
    modport slave  (input out_valid, out_data, out_sof, out_eol, output out_ready);
endinterface

// File: rtl/mt9v032_geom_counter.sv
// Pixel/line position counters with the terminal compares used for framing and geometry checks.
module mt9v032_geom_counter #(
    parameter int WIDTH  = 752,
    parameter int HEIGHT = 480,
    parameter int CW     = 10,
    parameter int LW     = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic px_active,
    input  logic lv_fall,
    input  logic line_clr,
    input  logic line_en,
    output logic in_geom,
    output logic sof,
    output logic eol,
    output logic line_ok,
    output logic frame_ok
);
    localparam logic [CW-1:0] W_C  = CW'(WIDTH);
    localparam logic [CW-1:0] W_M1 = CW'(WIDTH - 1);
    localparam logic [LW-1:0] H_C  = LW'(HEIGHT);

    logic [CW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic [LW-1:0] line_nxt;
    logic          line_inc;

    // Counters saturate so an over-long line/frame never wraps back into geometry.
    assign line_inc = line_en && lv_fall && (line_cnt != '1);
    assign line_nxt = line_inc ? line_cnt + 1'b1 : line_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else begin
            if (lv_fall)
                pix_cnt <= '0;
            else if (px_active && (pix_cnt != '1))
                pix_cnt <= pix_cnt + 1'b1;

            if (line_clr)
                line_cnt <= '0;
            else
                line_cnt <= line_nxt;
        end
    end

    assign in_geom  = (pix_cnt < W_C) && (line_cnt < H_C);
    assign sof      = (pix_cnt == '0) && (line_cnt == '0);
    assign eol      = (pix_cnt == W_M1);
    assign line_ok  = (pix_cnt == W_C);
    // Frame check sees a line closed in the same cycle as the frame end.
    assign frame_ok = (line_nxt == H_C);
endmodule

// File: rtl/mt9v032_capture_ctrl.sv
// Frame-aligned capture sequencer: arms on command, checks geometry, emits sof/eol-framed pixels.
module mt9v032_capture_ctrl
    import mt9v032_pkg::*;
#(
    parameter int PX_BITS = 10,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int CW      = 10,
    parameter int LW      = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_start,
    input  logic                  cmd_continuous,
    input  logic                  cmd_abort,
    input  logic [PX_BITS-1:0]    in_px,
    input  logic                  in_line_valid,
    input  logic                  in_frame_valid,
    mt9v032_capture_ctrl_if.master out_if,
    output logic                  busy,
    output logic                  done,
    output logic                  err_width,
    output logic                  err_height,
    output logic                  err_overflow,
    output logic [15:0]           frame_count
);
    cap_state_e state, state_nxt;

    logic               fv_q, lv_q, fv_qq, lv_qq;
    logic [PX_BITS-1:0] px_q;
    logic               cont_q;
    logic               fv_rise, fv_fall, lv_fall, px_active;
    logic               in_cap, line_clr, arm;
    logic               in_geom, sof, eol, line_ok, frame_ok;
    logic               take, drop_ovf;

    assign fv_rise   = fv_q & ~fv_qq;
    assign fv_fall   = ~fv_q & fv_qq;
    assign lv_fall   = ~lv_q & lv_qq;
    assign px_active = fv_q & lv_q;

    // Abort gates capture in its own cycle so nothing leaks out after it.
    assign in_cap   = (state == CAP) && !cmd_abort;
    assign line_clr = (state == WAIT_SOF) && fv_rise && !cmd_abort;
    assign arm      = (state == IDLE) && cmd_start && !cmd_abort;
    assign take     = in_cap && px_active && in_geom && out_if.out_ready;
    assign drop_ovf = in_cap && px_active && in_geom && !out_if.out_ready;

    mt9v032_geom_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .CW     (CW),
        .LW     (LW)
    ) u_geom (
        .clk      (clk),
        .rst_n    (rst_n),
        .px_active(px_active),
        .lv_fall  (lv_fall),
        .line_clr (line_clr),
        .line_en  (in_cap),
        .in_geom  (in_geom),
        .sof      (sof),
        .eol      (eol),
        .line_ok  (line_ok),
        .frame_ok (frame_ok)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cmd_start) state_nxt = SYNC;
            SYNC:     if (!fv_q)     state_nxt = WAIT_SOF;
            WAIT_SOF: if (fv_rise)   state_nxt = CAP;
            CAP:      if (fv_fall)   state_nxt = DONE;
            DONE:     state_nxt = cont_q ? WAIT_SOF : IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (cmd_abort)
            state_nxt = IDLE;
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fv_q             <= 1'b0;
            lv_q             <= 1'b0;
            fv_qq            <= 1'b0;
            lv_qq            <= 1'b0;
            px_q             <= '0;
            cont_q           <= 1'b0;
            err_width        <= 1'b0;
            err_height       <= 1'b0;
            err_overflow     <= 1'b0;
            frame_count      <= '0;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
            out_if.out_sof   <= 1'b0;
            out_if.out_eol   <= 1'b0;
        end else begin
            fv_q  <= in_frame_valid;
            lv_q  <= in_line_valid;
            px_q  <= in_px;
            fv_qq <= fv_q;
            lv_qq <= lv_q;

            out_if.out_valid <= take;
            out_if.out_data  <= take ? px_q : '0;
            out_if.out_sof   <= take && sof;
            out_if.out_eol   <= take && eol;

            if (arm) begin
                cont_q       <= cmd_continuous;
                err_width    <= 1'b0;
                err_height   <= 1'b0;
                err_overflow <= 1'b0;
            end else begin
                if (in_cap && lv_fall && !line_ok)
                    err_width <= 1'b1;
                if (in_cap && fv_fall && !frame_ok)
                    err_height <= 1'b1;
                if (drop_ovf)
                    err_overflow <= 1'b1;
            end

            if (state == DONE)
                frame_count <= frame_count + 16'd1;
        end
    end
endmodule
